ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Receives PS/2 keyboard frames (scan code set 2) and keeps one held-level per game key.
//  Sits upstream of the per-key edge-to-pulse synchronizers. Its key_* outputs are the level inputs those stages turn into one-cycle pulses.
//  Handles E0 extended prefix and F0 break prefix. Discards malformed frames.
// PARAMETERS
//  FILTER_LEN      8       consecutive equal samples needed before filtered ps2_clk changes level
//  TIMEOUT_CYCLES  100000  idle cycles mid-frame before the receiver abandons the frame (~1 ms @100 MHz)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  ps2_clk     in   1  raw PS/2 clock pin (asynchronous)
//  ps2_data    in   1  raw PS/2 data pin (asynchronous)
//  key_left    out  1  level: E0 6B held
//  key_right   out  1  level: E0 74 held
//  key_down    out  1  level: E0 72 held (soft drop)
//  key_rotate  out  1  level: E0 75 held (up arrow)
//  key_drop    out  1  level: 29 held (space, hard drop)
//  key_hold    out  1  level: 21 held ('C', hold piece)
//  scan_valid  out  1  one-cycle pulse per good byte received
//  scan_code   out  8  last good byte; stable until the next scan_valid
//  frame_err   out  1  one-cycle pulse on a parity error, stop-bit error or timeout
// BEHAVIOUR
//  Reset: all outputs 0; the sync/filter registers go to 1 (bus idle); FSMs go to IDLE; the prefix flags are cleared.
//  Input path: 2-FF synchronizer on both pins.
//   - Filtered clock changes only after FILTER_LEN identical synced samples.
//   - A falling edge of the filtered clock samples synced data in the same cycle.
//  Frame FSM, advanced on each falling edge:
//   - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay in IDLE (noise).
//   - DATA: shift in LSB first. After the 8th bit -> PARITY.
//   - PARITY: store the bit -> STOP.
//   - STOP: data=1 and odd parity over the 9 bits -> good byte, otherwise error. Always -> IDLE.
//   - Watchdog: in any state other than IDLE, TIMEOUT_CYCLES cycles without a falling edge -> IDLE plus a frame_err pulse.
//  Latency: scan_valid or frame_err is asserted in the cycle after the stop-bit edge is detected.
//  Byte decoder, acting on scan_valid:
//   - E0 sets ext.
//   - F0 sets brk.
//   - Any other byte is the key code. Level = !brk. The key is matched with ext (arrows need ext=1; space and C need ext=0).
//   - After a key-code byte, ext and brk clear whether or not the code matched.
//   - The key_* register updates in the same cycle scan_valid is high. Visible latency from the stop-bit edge is 1 clk.
//   - Unmapped codes change no key output.
//   - A repeated make (typematic) leaves an already-held key at 1.
//  On frame_err, ext and brk are cleared. Key levels are kept, because a lost break is tolerated until the next make/break.
//  Both keys may be held at once. Each key output is independent.
//  Reset mid-frame: everything returns to the reset state immediately. The partial frame is lost and no pulse is issued.
// STRUCTURE
//  Package tetris_input_pkg:
//   - localparam scan codes: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_LEFT=8'h6B, SC_RIGHT=8'h74, SC_DOWN=8'h72, SC_UP=8'h75, SC_SPACE=8'h29, SC_C=8'h21.
//   - rx_state_t enum {IDLE, DATA, PARITY, STOP}.
//  Sub-module ps2_rx: synchronizer, filter, frame FSM and watchdog. Outputs byte, valid and err.
//  The decoder and key registers stay in this module.
// TESTING (FILTER_LEN=8, TIMEOUT_CYCLES=2000, PS/2 bit period 400 clk)
//  1. Send E0 6B -> key_left goes 1 one clk after the 2nd stop edge; scan_valid pulses twice (E0, 6B). Then send E0 F0 6B -> key_left returns to 0.
//  2. Send 29, then 21, then F0 29 -> key_drop=1 and key_hold=1; after the break key_drop=0 while key_hold stays 1.
//  3. Send 6B with bad parity -> frame_err pulses once, scan_valid never pulses, keys unchanged. Then send E0 6B -> key_left=1.
//  4. Send start plus 3 data bits, then stop toggling -> frame_err pulses about 2000 clk later. A following good 29 -> key_drop=1.
//  5. Inject 3-clk glitches on ps2_clk while idle -> no state change and no pulses.
//  6. Assert rst in the middle of the DATA bits of F0 while key_right=1 -> all outputs 0. The next clean frame decodes correctly.

Source files
------------

// File: rtl/tetris_input_pkg.sv
// Shared scan codes, receiver state encoding and parity helper for the PS/2 key decoder.
package tetris_input_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_C     = 8'h21;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Odd parity: the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, frame FSM and idle watchdog.
// The *_next outputs carry this cycle's decision; rx_* are the same results registered.
module ps2_rx
  import tetris_input_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_next,
  output logic       good_next,
  output logic       err_next,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_clk_q, filt_clk_d;
  logic          fall_s;
  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, err_q;

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    filt_clk_d = filt_clk_q;
    if (clk_sync_q != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  assign fall_s = filt_clk_q & ~filt_clk_d;

  // Frame FSM stepped on filtered falling edges; the watchdog aborts stalled frames.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    good_next = 1'b0;
    err_next  = 1'b0;
    if (state_q == IDLE || fall_s) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
    if (fall_s) begin
      case (state_q)
        IDLE: begin
          if (!data_sync_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            state_d = DATA;
          end
        end
        PARITY: begin
          par_d   = data_sync_q;
          state_d = STOP;
        end
        STOP: begin
          if (data_sync_q && odd_parity_ok(shift_q, par_q)) begin
            good_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = IDLE;
      err_next = 1'b1;
    end else begin
      err_next = 1'b0;
    end
  end

  assign byte_next = shift_q;

  // Last good byte is held until the next good frame.
  always_comb begin
    if (good_next) begin
      byte_d = shift_q;
    end else begin
      byte_d = byte_q;
    end
  end

  // State registers; pins idle high so synchronizers and filter reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_cnt_q  <= '0;
      filt_clk_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      timer_q     <= '0;
      byte_q      <= 8'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_cnt_q  <= filt_cnt_d;
      filt_clk_q  <= filt_clk_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      timer_q     <= timer_d;
      byte_q      <= byte_d;
      valid_q     <= good_next;
      err_q       <= err_next;
    end
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 decoder keeping one held level per game key, with E0/F0 prefix tracking.
// Key registers load on the same edge that raises scan_valid, so both appear together.
module ps2_key_decoder
  import tetris_input_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop,
  output logic       key_hold,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  logic [7:0] byte_s;
  logic       good_s, err_s;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic [5:0] keys_q, keys_d;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_next(byte_s),
    .good_next(good_s),
    .err_next (err_s),
    .rx_byte  (scan_code),
    .rx_valid (scan_valid),
    .rx_err   (frame_err)
  );

  // Prefix tracking and key-level update; bit order matches the key_* output list.
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    keys_d = keys_q;
    if (err_s) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (good_s) begin
      case (byte_s)
        SC_EXT: ext_d = 1'b1;
        SC_BRK: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (ext_q) begin
            case (byte_s)
              SC_LEFT:  keys_d[0] = ~brk_q;
              SC_RIGHT: keys_d[1] = ~brk_q;
              SC_DOWN:  keys_d[2] = ~brk_q;
              SC_UP:    keys_d[3] = ~brk_q;
              default:  keys_d    = keys_q;
            endcase
          end else begin
            case (byte_s)
              SC_SPACE: keys_d[4] = ~brk_q;
              SC_C:     keys_d[5] = ~brk_q;
              default:  keys_d    = keys_q;
            endcase
          end
        end
      endcase
    end else begin
      keys_d = keys_q;
    end
  end

  // Decoder registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      keys_q <= 6'd0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      keys_q <= keys_d;
    end
  end

  assign key_left   = keys_q[0];
  assign key_right  = keys_q[1];
  assign key_down   = keys_q[2];
  assign key_rotate = keys_q[3];
  assign key_drop   = keys_q[4];
  assign key_hold   = keys_q[5];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: PS/2 frames are driven on the pins, an event queue plus a key-level model
// predicts every scan_valid/frame_err pulse and the key outputs on every cycle.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_data;
  logic       key_left, key_right, key_down, key_rotate, key_drop, key_hold;
  logic       scan_valid, frame_err;
  logic [7:0] scan_code;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_left(key_left), .key_right(key_right), .key_down(key_down),
    .key_rotate(key_rotate), .key_drop(key_drop), .key_hold(key_hold),
    .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        cur_ev;
  logic [5:0] m_keys;
  logic       m_ext, m_brk;
  logic [7:0] m_code;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_valid = 0;
  logic [5:0] keys_v;

  assign keys_v = {key_hold, key_drop, key_rotate, key_down, key_right, key_left};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key slot for a code given the extended prefix; -1 when the code drives no key.
  function automatic int key_slot(input logic [7:0] c, input logic e);
    if (e) begin
      if (c == 8'h6B) return 0;
      if (c == 8'h74) return 1;
      if (c == 8'h72) return 2;
      if (c == 8'h75) return 3;
    end else begin
      if (c == 8'h29) return 4;
      if (c == 8'h21) return 5;
    end
    return -1;
  endfunction

  task automatic apply_event(input ev_t e);
    int s;
    if (e.is_err) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_code = e.code;
      if (e.code == 8'hE0) m_ext = 1'b1;
      else if (e.code == 8'hF0) m_brk = 1'b1;
      else begin
        s = key_slot(e.code, m_ext);
        if (s >= 0) m_keys[s] = ~m_brk;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_keys = 6'd0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_code = 8'd0;
    exp_q.delete();
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", {16'd0, keys_v, scan_valid, scan_code, frame_err}, 32'd0);
    end else begin
      if (scan_valid || frame_err) begin
        if (scan_valid) n_valid++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, scan_valid, frame_err}, 32'd0);
        end else begin
          cur_ev = exp_q.pop_front();
          check("pulse_kind", {30'd0, scan_valid, frame_err}, cur_ev.is_err ? 32'd1 : 32'd2);
          apply_event(cur_ev);
        end
      end
      check("keys", {26'd0, keys_v}, {26'd0, m_keys});
      check("scan_code", {24'd0, scan_code}, {24'd0, m_code});
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [10:0] bits, input int nb, input int half);
    for (int i = 0; i < nb; i++) begin
      ps2_data = bits[i];
      wait_clk(half);
      ps2_clk = 1'b0;
      wait_clk(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b);
    if (bad_par) p = ~p;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
    ev_t e;
    e.is_err = bad_par | bad_stop;
    e.code   = b;
    exp_q.push_back(e);
    drive_frame(frame_bits(b, bad_par, bad_stop), 11, half);
    wait_clk((half < 30) ? 60 : 2 * half);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  // Hard stop if the run ever wedges.
  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    int v0, n;
    logic [7:0] codes [8];
    logic [7:0] b;
    int half;
    int r;
    codes[0] = 8'hE0; codes[1] = 8'hF0; codes[2] = 8'h6B; codes[3] = 8'h74;
    codes[4] = 8'h72; codes[5] = 8'h75; codes[6] = 8'h29; codes[7] = 8'h21;

    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    check("post_reset_keys", {26'd0, keys_v}, 32'd0);

    // 1: extended make / break of the left arrow
    v0 = n_valid;
    send(8'hE0, 0, 0, 200);
    send(8'h6B, 0, 0, 200);
    check("t1_valid_count", n_valid - v0, 32'd2);
    check("t1_left_make", {31'd0, key_left}, 32'd1);
    check("t1_model_pin", {26'd0, m_keys}, 32'h01);
    send(8'hE0, 0, 0, 200);
    send(8'hF0, 0, 0, 200);
    send(8'h6B, 0, 0, 200);
    check("t1_left_break", {31'd0, key_left}, 32'd0);

    // 2: two plain keys held together, then one released
    send(8'h29, 0, 0, 100);
    send(8'h21, 0, 0, 100);
    check("t2_both_held", {30'd0, key_hold, key_drop}, 32'd3);
    send(8'hF0, 0, 0, 100);
    send(8'h29, 0, 0, 100);
    check("t2_drop_released", {30'd0, key_hold, key_drop}, 32'd2);

    // 3: parity error leaves keys alone, then a good make
    v0 = n_valid;
    send(8'h6B, 1, 0, 200);
    check("t3_no_valid", n_valid - v0, 32'd0);
    check("t3_left_still_0", {31'd0, key_left}, 32'd0);
    send(8'hE0, 0, 0, 200);
    send(8'h6B, 0, 0, 200);
    check("t3_left_make", {31'd0, key_left}, 32'd1);
    check("t3_model_pin", {26'd0, m_keys}, 32'h21);

    // 4: stalled frame -> watchdog error, then a good byte
    cur_ev.is_err = 1'b1;
    cur_ev.code = 8'h00;
    exp_q.push_back(cur_ev);
    drive_frame(frame_bits(8'h29, 0, 0), 4, 200);
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      wait_clk(1);
      n++;
    end
    check("t4_timeout_seen", exp_q.size(), 32'd0);
    check("t4_timeout_latency_ok", {31'd0, (n >= 1780 && n <= 1840)}, 32'd1);
    wait_clk(20);
    send(8'h29, 0, 0, 200);
    check("t4_drop_make", {31'd0, key_drop}, 32'd1);

    // 5: short clock glitches while idle are ignored
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      wait_clk(3);
      ps2_clk = 1'b1;
      wait_clk(50);
    end
    send(8'hF0, 0, 0, 50);
    send(8'h21, 0, 0, 50);
    check("t5_hold_break", {31'd0, key_hold}, 32'd0);

    // 6: reset in the middle of a frame
    send(8'hE0, 0, 0, 50);
    send(8'h74, 0, 0, 50);
    check("t6_right_held", {31'd0, key_right}, 32'd1);
    drive_frame(frame_bits(8'hF0, 0, 0), 5, 50);
    rst = 1'b1;
    model_reset();
    wait_clk(4);
    check("t6_right_in_reset", {31'd0, key_right}, 32'd0);
    rst = 1'b0;
    wait_clk(20);
    send(8'hE0, 0, 0, 50);
    send(8'h75, 0, 0, 50);
    check("t6_after_reset", {26'd0, keys_v}, 32'h08);

    // Randomized frames, codes biased towards prefixes and mapped keys
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 9);
      if (r < 8) b = codes[r];
      else b = 8'($urandom_range(0, 255));
      half = $urandom_range(15, 25);
      r = $urandom_range(0, 7);
      send(b, r == 0, r == 1, half);
    end

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
